// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-ported, registered-read memory between
// two bus masters; one queued request per port, per-port read holding register.
module mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] m0_addr,
  input  logic        m0_rstrb,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic [31:0] m0_rdata,
  output logic        m0_busy,
  input  logic [31:0] m1_addr,
  input  logic        m1_rstrb,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic [31:0] m1_rdata,
  output logic        m1_busy,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned NP = 2;

  typedef enum logic {S_IDLE = 1'b0, S_RDATA = 1'b1} state_t;

  state_t          r_state;
  logic            r_gnt;
  logic            r_last;
  logic [NP-1:0]   r_pend;
  logic [NP-1:0]   r_is_rd;
  logic [AW-1:0]   r_addr  [NP];
  logic [DW-1:0]   r_wdata [NP];
  logic [MW-1:0]   r_wmask [NP];
  logic [DW-1:0]   r_rdata [NP];

  logic            w_stb   [NP];
  logic            w_rd    [NP];
  logic [AW-1:0]   w_addr  [NP];
  logic [DW-1:0]   w_wdata [NP];
  logic [MW-1:0]   w_wmask [NP];
  logic            w_any;
  logic            w_both;
  logic            w_win;
  logic            w_issue;

  // Any nonzero mask makes the strobe a write, overriding a concurrent read.
  assign w_addr[0]  = m0_addr;
  assign w_addr[1]  = m1_addr;
  assign w_wdata[0] = m0_wdata;
  assign w_wdata[1] = m1_wdata;
  assign w_wmask[0] = m0_wmask;
  assign w_wmask[1] = m1_wmask;
  assign w_stb[0]   = m0_rstrb | (|m0_wmask);
  assign w_stb[1]   = m1_rstrb | (|m1_wmask);
  assign w_rd[0]    = m0_rstrb & ~(|m0_wmask);
  assign w_rd[1]    = m1_rstrb & ~(|m1_wmask);

  assign m0_rdata = r_rdata[0];
  assign m1_rdata = r_rdata[1];
  assign m0_busy  = r_pend[0];
  assign m1_busy  = r_pend[1];

  // Winner selection and memory drive straight from the request registers.
  always_comb begin
    w_any     = |r_pend;
    w_both    = &r_pend;
    w_win     = 1'b0;
    w_issue   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    if (w_both) begin
      w_win = RR_EN ? ~r_last : 1'b0;
    end else begin
      w_win = ~r_pend[0];
    end
    if (r_state == S_IDLE && w_any) begin
      w_issue   = 1'b1;
      mem_addr  = r_addr[w_win];
      mem_wdata = r_wdata[w_win];
      mem_rstrb = r_is_rd[w_win];
      mem_wmask = r_is_rd[w_win] ? MW'(0) : r_wmask[w_win];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_pend  <= '0;
      r_is_rd <= '0;
      for (int unsigned p = 0; p < NP; p++) begin
        r_addr[p]  <= '0;
        r_wdata[p] <= '0;
        r_wmask[p] <= '0;
        r_rdata[p] <= '0;
      end
    end else begin
      // Accept only when idle; a strobe while busy is silently dropped.
      for (int unsigned p = 0; p < NP; p++) begin
        if (!r_pend[p] && w_stb[p]) begin
          r_pend[p]  <= 1'b1;
          r_is_rd[p] <= w_rd[p];
          r_addr[p]  <= w_addr[p];
          r_wdata[p] <= w_wdata[p];
          r_wmask[p] <= w_wmask[p];
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            // Rotation pointer only moves when two ports actually contended.
            if (w_both) r_last <= w_win;
            if (r_is_rd[w_win]) begin
              r_gnt   <= w_win;
              r_state <= S_RDATA;
            end else begin
              r_pend[w_win] <= 1'b0;
            end
          end
        end
        S_RDATA: begin
          r_rdata[r_gnt] <= mem_rdata;
          r_pend[r_gnt]  <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
